// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
// Breakpoint logic is enabled by defining PC_BREAKPOINT_EN.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_STEP
  } state_t;

  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int IT_R = 0;
  localparam int IT_I = 1;
  localparam int IT_S = 2;
  localparam int IT_B = 3;
  localparam int IT_U = 4;
  localparam int IT_J = 5;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC target selection, wrap masking and
// misalignment detection.
module next_pc_calc #(
  parameter logic [31:0] MASK = 32'h3F
) (
  input  logic [31:0] i_pc,
  input  logic [5:0]  i_itype,
  input  logic [6:0]  i_opcode,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_rs1,
  input  logic        i_taken,
  output logic [31:0] next_pc,
  output logic        misaligned
);
  import pc_seq_pkg::*;

  logic [31:0] w_raw;
  logic        w_is_jalr;
  logic        w_is_br;
  logic [4:0]  w_unused_dec;

  assign w_is_jalr = i_itype[IT_I] && (i_opcode == OPC_JALR);
  assign w_is_br   = i_itype[IT_B] && i_taken;

  // Decode relies on the one-hot type field; opcode only
  // disambiguates jalr from other I-type instructions.
  assign w_unused_dec = {
    i_itype[IT_U], i_itype[IT_S], i_itype[IT_R],
    i_opcode == OPC_JAL, i_opcode == OPC_BRANCH
  };

  always_comb begin
    w_raw = i_pc + 32'd4;
    unique case (1'b1)
      i_itype[IT_J]: w_raw = i_pc + i_imm;
      w_is_jalr:     w_raw = (i_rs1 + i_imm) & ~32'd1;
      w_is_br:       w_raw = i_pc + i_imm;
      default:       w_raw = i_pc + 32'd4;
    endcase
  end

  assign next_pc    = w_raw & MASK;
  assign misaligned = w_raw[1];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and run/halt/step control for the core.
// Optional breakpoint halting: define PC_BREAKPOINT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          IMEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  instruction_type,
  input  logic [6:0]  opcode,
  input  logic [31:0] immediate,
  input  logic [31:0] rs1_data,
  input  logic        branch_taken,
  input  logic        la_run,
  input  logic        la_halt,
  input  logic        la_step,
  input  logic        la_pc_load,
  input  logic [31:0] la_pc_value,
  input  logic [31:0] la_bp_addr,
  input  logic        la_bp_enable,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic        bp_hit,
  output logic [31:0] retire_count
);
  import pc_seq_pkg::*;

  localparam logic [31:0] MASK = 32'(IMEM_WORDS * 4 - 1);

  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx;
  logic [31:0] r_ret, w_ret_nx;
  logic        r_fault, w_fault_nx;
  logic        r_bp, w_bp_nx;
  logic        r_step_q;
  logic        w_step_rise;
  logic        w_adv;
  logic [31:0] w_next_pc;
  logic        w_misal;
  logic        w_bp_match;

  next_pc_calc #(.MASK(MASK)) u_calc (
    .i_pc       (r_pc),
    .i_itype    (instruction_type),
    .i_opcode   (opcode),
    .i_imm      (immediate),
    .i_rs1      (rs1_data),
    .i_taken    (branch_taken),
    .next_pc    (w_next_pc),
    .misaligned (w_misal)
  );

`ifdef PC_BREAKPOINT_EN
  assign w_bp_match = la_bp_enable &&
    (w_next_pc == (la_bp_addr & MASK));
`else
  logic w_unused_bp;
  assign w_unused_bp = ^{la_bp_addr, la_bp_enable};
  assign w_bp_match  = 1'b0;
`endif

  assign w_step_rise = la_step & ~r_step_q;

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_ret_nx   = r_ret;
    w_fault_nx = r_fault;
    w_bp_nx    = r_bp;
    w_adv      = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (w_misal) begin
          w_fault_nx = 1'b1;
          w_state_nx = ST_HALT;
        end else if (la_halt || r_fault) begin
          w_state_nx = ST_HALT;
        end else begin
          w_adv = 1'b1;
          if (w_bp_match) begin
            w_bp_nx    = 1'b1;
            w_state_nx = ST_HALT;
          end
        end
      end
      ST_STEP: begin
        w_state_nx = ST_HALT;
        if (w_misal)
          w_fault_nx = 1'b1;
        else if (!la_halt && !r_fault)
          w_adv = 1'b1;
      end
      ST_HALT: begin
        if (la_halt) begin
          w_state_nx = ST_HALT;
        end else if (la_pc_load) begin
          w_pc_nx    = la_pc_value & MASK & ~32'd3;
          w_ret_nx   = 32'd0;
          w_fault_nx = 1'b0;
          w_bp_nx    = 1'b0;
        end else if (w_step_rise) begin
          w_state_nx = ST_STEP;
        end else if (la_run) begin
          w_state_nx = ST_RUN;
          w_bp_nx    = 1'b0;
        end
      end
      default: w_state_nx = ST_HALT;
    endcase
    if (w_adv) begin
      w_pc_nx  = w_next_pc;
      w_ret_nx = r_ret + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_PC;
      r_ret    <= 32'd0;
      r_fault  <= 1'b0;
      r_bp     <= 1'b0;
      r_step_q <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_pc     <= w_pc_nx;
      r_ret    <= w_ret_nx;
      r_fault  <= w_fault_nx;
      r_bp     <= w_bp_nx;
      r_step_q <= la_step;
    end
  end

  assign pc           = r_pc;
  assign pc_plus4     = (r_pc + 32'd4) & MASK;
  assign halted       = (r_state == ST_HALT);
  assign fault        = r_fault;
  assign bp_hit       = r_bp;
  assign retire_count = r_ret;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table plus
// hand sequences for stepping, breakpoints and async reset.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic [5:0]  itype;
  logic [6:0]  opc;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        taken;
  logic        run, halt, step, load;
  logic [31:0] ldv;
  logic [31:0] bpa;
  logic        bpen;
  logic [31:0] pc, pc4, ret;
  logic        halted, fault, bph;

  int checks = 0;
  int errors = 0;

`ifdef PC_BREAKPOINT_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  localparam logic [5:0] T_I = 6'b000010;
  localparam logic [5:0] T_B = 6'b001000;
  localparam logic [5:0] T_J = 6'b100000;
  localparam logic [6:0] O_NOP = 7'h13;
  localparam logic [6:0] O_JR  = 7'h67;
  localparam logic [6:0] O_BR  = 7'h63;
  localparam logic [6:0] O_JAL = 7'h6F;
  localparam logic [31:0] M12  = 32'hFFFF_FFF4;

  typedef struct packed {
    logic [5:0]  ity;
    logic [6:0]  opc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        tk;
    logic [3:0]  ctl;
    logic [31:0] ldv;
    logic [31:0] pc;
    logic [31:0] ret;
    logic        h;
    logic        f;
    logic        bp;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ret;
    logic        h;
    logic        f;
    logic        bp;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  pc_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instruction_type (itype),
    .opcode           (opc),
    .immediate        (imm),
    .rs1_data         (rs1),
    .branch_taken     (taken),
    .la_run           (run),
    .la_halt          (halt),
    .la_step          (step),
    .la_pc_load       (load),
    .la_pc_value      (ldv),
    .la_bp_addr       (bpa),
    .la_bp_enable     (bpen),
    .pc               (pc),
    .pc_plus4         (pc4),
    .halted           (halted),
    .fault            (fault),
    .bp_hit           (bph),
    .retire_count     (ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t v(
    input logic [5:0] ty, input logic [6:0] op,
    input logic [31:0] im, input logic [31:0] r1,
    input logic tk, input logic [3:0] ctl,
    input logic [31:0] lv, input logic [31:0] epc,
    input logic [31:0] er, input logic eh,
    input logic ef, input logic eb);
    vec_t t;
    t.ity = ty; t.opc = op; t.imm = im; t.rs1 = r1;
    t.tk = tk; t.ctl = ctl; t.ldv = lv;
    t.pc = epc; t.ret = er; t.h = eh; t.f = ef;
    t.bp = eb;
    return t;
  endfunction

  function automatic vec_t n(
    input logic [3:0] ctl, input logic [31:0] lv,
    input logic [31:0] epc, input logic [31:0] er,
    input logic eh, input logic ef);
    return v(T_I, O_NOP, 0, 0, 0, ctl, lv,
             epc, er, eh, ef, 1'b0);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    exp_t e;
    itype = t.ity; opc = t.opc; imm = t.imm;
    rs1 = t.rs1; taken = t.tk;
    halt = t.ctl[3]; load = t.ctl[2];
    step = t.ctl[1]; run = t.ctl[0];
    ldv = t.ldv;
    sb.push_back('{t.pc, t.ret, t.h, t.f, t.bp});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pc"}, pc, e.pc);
      chk({tag, ".pc4"}, pc4, (e.pc + 32'd4) & 32'h3F);
      chk({tag, ".ret"}, ret, e.ret);
      chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e.h});
      chk({tag, ".fault"}, {31'd0, fault}, {31'd0, e.f});
      chk({tag, ".bp_hit"}, {31'd0, bph}, {31'd0, e.bp});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    itype = T_I; opc = O_NOP; imm = 0; rs1 = 0;
    taken = 0; run = 0; halt = 0; step = 0; load = 0;
    ldv = 0; bpa = 0; bpen = 0;

    // ctl = {halt, load, step, run}
    tbl.push_back(n(4'h0, 0, 32'd4, 1, 0, 0));
    tbl.push_back(n(4'h0, 0, 32'd8, 2, 0, 0));
    tbl.push_back(n(4'h0, 0, 32'd12, 3, 0, 0));
    tbl.push_back(n(4'h0, 0, 32'd16, 4, 0, 0));
    tbl.push_back(n(4'h8, 0, 32'd16, 4, 1, 0));
    tbl.push_back(n(4'h4, 60, 32'd60, 0, 1, 0));
    tbl.push_back(n(4'h1, 0, 32'd60, 0, 0, 0));
    tbl.push_back(n(4'h0, 0, 32'd0, 1, 0, 0));
    tbl.push_back(n(4'h8, 0, 32'd0, 1, 1, 0));
    tbl.push_back(n(4'h4, 24, 32'd24, 0, 1, 0));
    tbl.push_back(n(4'h1, 0, 32'd24, 0, 0, 0));
    tbl.push_back(v(T_B, O_BR, M12, 0, 1, 4'h0, 0,
                    32'd12, 1, 0, 0, 0));
    tbl.push_back(n(4'h8, 0, 32'd12, 1, 1, 0));
    tbl.push_back(n(4'h4, 24, 32'd24, 0, 1, 0));
    tbl.push_back(n(4'h1, 0, 32'd24, 0, 0, 0));
    tbl.push_back(v(T_B, O_BR, M12, 0, 0, 4'h0, 0,
                    32'd28, 1, 0, 0, 0));
    tbl.push_back(v(T_I, O_JR, 0, 32'h31, 0, 4'h0, 0,
                    32'h30, 2, 0, 0, 0));
    tbl.push_back(v(T_I, O_JR, 0, 32'h32, 0, 4'h0, 0,
                    32'h30, 2, 1, 1, 0));
    tbl.push_back(n(4'h0, 0, 32'h30, 2, 1, 1));
    tbl.push_back(n(4'h4, 32'h20, 32'h20, 0, 1, 0));
    tbl.push_back(n(4'h1, 0, 32'h20, 0, 0, 0));
    tbl.push_back(n(4'h0, 0, 32'h24, 1, 0, 0));
    tbl.push_back(v(T_I, O_JR, 0, 32'h32, 0, 4'h8, 0,
                    32'h24, 1, 1, 1, 0));
    tbl.push_back(n(4'h4, 32'hFFFF_FFFF, 32'h3C, 0, 1, 0));
    tbl.push_back(n(4'h1, 0, 32'h3C, 0, 0, 0));
    tbl.push_back(n(4'h4, 32'h8, 32'h00, 1, 0, 0));
    tbl.push_back(v(T_J, O_JAL, 32'd8, 0, 0, 4'h0, 0,
                    32'd8, 2, 0, 0, 0));
    tbl.push_back(n(4'h9, 0, 32'd8, 2, 1, 0));
    tbl.push_back(n(4'h5, 32'h10, 32'h10, 0, 1, 0));
    tbl.push_back(n(4'h3, 0, 32'h10, 0, 0, 0));
    tbl.push_back(n(4'h2, 0, 32'h14, 1, 1, 0));
    tbl.push_back(n(4'h2, 0, 32'h14, 1, 1, 0));
    tbl.push_back(n(4'h0, 0, 32'h14, 1, 1, 0));

    #12;
    chk("rst.pc", pc, 32'h0);
    chk("rst.pc4", pc4, 32'h4);
    chk("rst.ret", ret, 32'h0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.fault", {31'd0, fault}, 32'd0);
    chk("rst.bp_hit", {31'd0, bph}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Held step level from HALT at pc=8 gives one step
    apply(n(4'h4, 0, 32'd0, 0, 1, 0), "st.ld");
    apply(n(4'h1, 0, 32'd0, 0, 0, 0), "st.run");
    apply(n(4'h0, 0, 32'd4, 1, 0, 0), "st.n1");
    apply(n(4'h0, 0, 32'd8, 2, 0, 0), "st.n2");
    apply(n(4'h8, 0, 32'd8, 2, 1, 0), "st.halt");
    apply(n(4'h2, 0, 32'd8, 2, 0, 0), "st.s1");
    apply(n(4'h2, 0, 32'd12, 3, 1, 0), "st.s2");
    for (int k = 0; k < 3; k++)
      apply(n(4'h2, 0, 32'd12, 3, 1, 0),
            $sformatf("st.hold%0d", k));
    apply(n(4'h4, 32'h20, 32'h20, 0, 1, 0), "st.load");

    // Breakpoint at 0x10 while running from 0
    bpa = 32'h10; bpen = 1'b1;
    apply(n(4'h4, 0, 32'd0, 0, 1, 0), "bp.ld");
    apply(n(4'h1, 0, 32'd0, 0, 0, 0), "bp.run");
    apply(n(4'h0, 0, 32'd4, 1, 0, 0), "bp.n1");
    apply(n(4'h0, 0, 32'd8, 2, 0, 0), "bp.n2");
    apply(n(4'h0, 0, 32'd12, 3, 0, 0), "bp.n3");
    apply(v(T_I, O_NOP, 0, 0, 0, 4'h0, 0,
            32'h10, 4, BP, 0, BP), "bp.hit");
    apply(n(4'h1, 0, BP ? 32'h10 : 32'h14,
            BP ? 32'd4 : 32'd5, 0, 0), "bp.resume");
    apply(n(4'h0, 0, BP ? 32'h14 : 32'h18,
            BP ? 32'd5 : 32'd6, 0, 0), "bp.next");
    bpen = 1'b0;

    // Asynchronous reset between clock edges
    apply(n(4'h8, 0, BP ? 32'h14 : 32'h18,
            BP ? 32'd5 : 32'd6, 1, 0), "ar.halt");
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.pc", pc, 32'h0);
    chk("ar.pc4", pc4, 32'h4);
    chk("ar.ret", ret, 32'h0);
    chk("ar.halted", {31'd0, halted}, 32'd0);
    #3;
    rst_n = 1'b1;
    apply(n(4'h0, 0, 32'd4, 1, 0, 0), "ar.n1");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
